mc_control_unit: RTL and testbench

- Multi-cycle control FSM for the nano RV32I core. It is the initiator side of the ALU interface.
- Decodes the latched instruction and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU opcode and operand selects, and consumes the ALU zero flag to resolve branches.
- Sits between the instruction register / memory port and the datapath muxes, register file and PC.

---
 rtl/rv32i_pkg.sv | 85 ++++++++
 rtl/mc_control_unit_alu_op_decoder.sv | 47 ++++
 rtl/mc_control_unit.sv | 173 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared constants for the nano RV32I core: ALU opcodes, RV32I encodings,
// control FSM state encoding and datapath mux selects.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SGEU = 4'b1010;
  localparam logic [3:0] ALU_SGE  = 4'b1011;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Register-register ops use funct7[5] for SUB and SRA; immediate ops only for SRAI.
  function automatic logic [3:0] alu_fn(input logic [2:0] funct3,
                                        input logic       funct7_b5,
                                        input logic       is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      F3_ADD:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = funct7_b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_op_decoder.sv
// Combinational map from {opcode, funct3, funct7[5]} to the ALU opcode and
// a legality flag used by the control FSM to detect illegal instructions.
module alu_op_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal  = 1'b1;
        alu_op = alu_fn(funct3, funct7_b5, 1'b1);
      end
      OPC_OP_IMM: begin
        legal  = 1'b1;
        alu_op = alu_fn(funct3, funct7_b5, 1'b0);
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE: alu_op = ALU_SUB;
          F3_BLT:         alu_op = ALU_SLT;
          F3_BGE:         alu_op = ALU_SGE;
          F3_BLTU:        alu_op = ALU_SLTU;
          F3_BGEU:        alu_op = ALU_SGEU;
          default:        legal  = 1'b0;
        endcase
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: begin
        legal  = 1'b1;
        alu_op = ALU_ADD;
      end
      default: begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the nano RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath/ALU controls.
module mc_control_unit
  import rv32i_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0,
  parameter bit         HAS_TRAP    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_inc_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_is_fetch_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic        trap_o,
  output logic [2:0]  state_o
);

  state_t     state_reg, state_next;
  logic       trap_reg;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       funct7_b5;
  logic [3:0] dec_alu_op;
  logic       dec_legal;
  logic       is_mem_op;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode    = instr_i[6:0];
  assign rd        = instr_i[11:7];
  assign funct3    = instr_i[14:12];
  assign funct7_b5 = instr_i[30];
  assign is_mem_op = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

  // Immediate and register-index fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15]};

  alu_op_decoder u_alu_op_decoder (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .alu_op    (dec_alu_op),
    .legal     (dec_legal)
  );

  // BEQ is the only branch taken on a zero ALU result.
  assign branch_taken = (funct3 == F3_BEQ) ? alu_zero_i : ~alu_zero_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= state_t'(RESET_STATE);
      trap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      trap_reg  <= trap_reg | (state_next == S_TRAP);
    end
  end

  always_comb begin
    state_next     = state_reg;
    alu_op_o       = ALU_ADD;
    alu_src_a_o    = SRC_A_RS1;
    alu_src_b_o    = SRC_B_RS2;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_inc_o       = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_is_fetch_o = 1'b0;
    reg_write_o    = 1'b0;
    wb_sel_o       = WB_ALU;
    case (state_reg)
      S_FETCH: begin
        mem_req_o      = 1'b1;
        mem_is_fetch_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_inc_o   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_next = HAS_TRAP ? S_TRAP : S_FETCH;
        end else if (opcode == OPC_BRANCH) begin
          state_next = S_BRANCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_o = dec_alu_op;
        case (opcode)
          OPC_OP: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_RS2;
          end
          OPC_LUI: begin
            alu_src_a_o = SRC_A_ZERO;
            alu_src_b_o = SRC_B_IMM;
          end
          OPC_AUIPC: begin
            alu_src_a_o = SRC_A_PC;
            alu_src_b_o = SRC_B_IMM;
          end
          OPC_JAL: begin
            alu_src_a_o = SRC_A_PC;
            alu_src_b_o = SRC_B_IMM;
            pc_write_o  = 1'b1;
          end
          OPC_JALR: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_IMM;
            pc_write_o  = 1'b1;
          end
          default: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_IMM;
          end
        endcase
        state_next = is_mem_op ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (opcode == OPC_STORE);
        if (mem_ready_i) begin
          state_next = (opcode == OPC_LOAD) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write_o = (rd != 5'd0);
        if (opcode == OPC_LOAD) begin
          wb_sel_o = WB_MEM;
        end else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
          wb_sel_o = WB_PC4;
        end else begin
          wb_sel_o = WB_ALU;
        end
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // Target comes from a dedicated PC+imm adder, so pc_write rides on the compare.
        alu_op_o    = dec_alu_op;
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
        pc_write_o  = branch_taken;
        state_next  = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  assign trap_o  = trap_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle expected output snapshots
// are queued with their stimulus and compared as each cycle is played out.
module tb_mc_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        alu_zero_i;
  logic        mem_ready_i;
  logic [3:0]  alu_op_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic        ir_write_o;
  logic        pc_write_o;
  logic        pc_inc_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        mem_is_fetch_o;
  logic        reg_write_o;
  logic [1:0]  wb_sel_o;
  logic        trap_o;
  logic [2:0]  state_o;

  always #5 clk_i = ~clk_i;

  mc_control_unit #(.RESET_STATE(3'd0), .HAS_TRAP(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_i        (instr_i),
    .alu_zero_i     (alu_zero_i),
    .mem_ready_i    (mem_ready_i),
    .alu_op_o       (alu_op_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_inc_o       (pc_inc_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_is_fetch_o (mem_is_fetch_o),
    .reg_write_o    (reg_write_o),
    .wb_sel_o       (wb_sel_o),
    .trap_o         (trap_o),
    .state_o        (state_o)
  );

  typedef struct packed {
    logic [2:0] state;
    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       ir_write;
    logic       pc_write;
    logic       pc_inc;
    logic       mem_req;
    logic       mem_we;
    logic       mem_is_fetch;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       trap;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic ready;
    logic zero;
    obs_t exp;
  } step_t;

  step_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic [3:0] op,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic irw, input logic pcw, input logic pci,
                              input logic req, input logic we, input logic fch,
                              input logic rw, input logic [1:0] wb, input logic trp);
    obs_t o;
    o.state = st; o.alu_op = op; o.src_a = a; o.src_b = b;
    o.ir_write = irw; o.pc_write = pcw; o.pc_inc = pci;
    o.mem_req = req; o.mem_we = we; o.mem_is_fetch = fch;
    o.reg_write = rw; o.wb_sel = wb; o.trap = trp;
    return o;
  endfunction

  function automatic obs_t o_fetch(input logic rdy);
    return mk(3'd0, 4'd0, 2'd0, 2'd0, rdy, 1'b0, rdy, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic obs_t o_decode();
    return mk(3'd1, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic obs_t o_exec(input logic [3:0] op, input logic [1:0] a,
                                  input logic [1:0] b, input logic pcw);
    return mk(3'd2, op, a, b, 1'b0, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic obs_t o_mem(input logic we);
    return mk(3'd3, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, we, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic obs_t o_wb(input logic rw, input logic [1:0] wb);
    return mk(3'd4, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw, wb, 1'b0);
  endfunction
  function automatic obs_t o_branch(input logic [3:0] op, input logic pcw);
    return mk(3'd5, op, 2'd0, 2'd0, 1'b0, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic obs_t o_trap();
    return mk(3'd6, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic zero, input obs_t exp);
    step_t s;
    s.rst = rst; s.ready = rdy; s.zero = zero; s.exp = exp;
    sb.push_back(s);
  endtask

  // Drive the oldest queued step, sample mid-cycle, then move past the next edge.
  task automatic advance(output obs_t act, output obs_t exp);
    step_t s;
    s = sb.pop_front();
    rst_i       = s.rst;
    mem_ready_i = s.ready;
    alu_zero_i  = s.zero;
    @(negedge clk_i);
    act = mk(state_o, alu_op_o, alu_src_a_o, alu_src_b_o, ir_write_o, pc_write_o,
             pc_inc_o, mem_req_o, mem_we_o, mem_is_fetch_o, reg_write_o, wb_sel_o, trap_o);
    exp = s.exp;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    obs_t act, exp;
    int   n = 0;
    rst_i = 1'b1; mem_ready_i = 1'b0; alu_zero_i = 1'b0; instr_i = 32'h002081B3;
    repeat (2) @(posedge clk_i);
    #1;
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    push(1'b1, 1'b0, 1'b0, o_fetch(1'b0));
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b1, 1'b0, 1'b0, o_decode());
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL reset step %0d got=%h required=%h", n, act, exp);
      end
      n++;
    end
    $display("tx reset cycles=%0d", n);
  endtask

  task automatic run_alu(input string name, input logic [31:0] instr,
                         input obs_t exec_exp, input obs_t wb_exp);
    obs_t act, exp;
    int   n = 0;
    instr_i = instr;
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, o_decode());
    push(1'b0, 1'b0, 1'b0, exec_exp);
    push(1'b0, 1'b0, 1'b0, wb_exp);
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL %s step %0d got=%h required=%h", name, n, act, exp);
      end
      n++;
    end
    $display("tx %s instr=%h cycles=%0d", name, instr, n);
  endtask

  task automatic test_alu_ops();
    run_alu("add",   32'h002081B3, o_exec(4'b0000, 2'd0, 2'd0, 1'b0), o_wb(1'b1, 2'd0));
    run_alu("sub",   32'h402081B3, o_exec(4'b0001, 2'd0, 2'd0, 1'b0), o_wb(1'b1, 2'd0));
    run_alu("srai",  32'h4020D193, o_exec(4'b0111, 2'd0, 2'd1, 1'b0), o_wb(1'b1, 2'd0));
    run_alu("add_x0", 32'h00208033, o_exec(4'b0000, 2'd0, 2'd0, 1'b0), o_wb(1'b0, 2'd0));
    run_alu("lui",   32'h000122B7, o_exec(4'b0000, 2'd2, 2'd1, 1'b0), o_wb(1'b1, 2'd0));
    run_alu("jal",   32'h008000EF, o_exec(4'b0000, 2'd1, 2'd1, 1'b1), o_wb(1'b1, 2'd2));
  endtask

  task automatic run_branch(input string name, input logic [31:0] instr,
                            input logic zero, input logic [3:0] op, input logic taken);
    obs_t act, exp;
    int   n = 0;
    instr_i = instr;
    push(1'b0, 1'b1, zero, o_fetch(1'b1));
    push(1'b0, 1'b0, zero, o_decode());
    push(1'b0, 1'b0, zero, o_branch(op, taken));
    push(1'b0, 1'b0, zero, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL %s step %0d got=%h required=%h", name, n, act, exp);
      end
      n++;
    end
    $display("tx %s zero=%0b cycles=%0d", name, zero, n);
  endtask

  task automatic test_branch();
    run_branch("bne_taken",    32'h00209463, 1'b0, 4'b0001, 1'b1);
    run_branch("bne_nottaken", 32'h00209463, 1'b1, 4'b0001, 1'b0);
    run_branch("beq_taken",    32'h00208463, 1'b1, 4'b0001, 1'b1);
    run_branch("blt_nottaken", 32'h0020C463, 1'b1, 4'b1000, 1'b0);
  endtask

  task automatic test_load_store();
    obs_t act, exp;
    int   n = 0;
    instr_i = 32'h0000A283;
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, o_decode());
    push(1'b0, 1'b0, 1'b0, o_exec(4'b0000, 2'd0, 2'd1, 1'b0));
    repeat (3) push(1'b0, 1'b0, 1'b0, o_mem(1'b0));
    push(1'b0, 1'b1, 1'b0, o_mem(1'b0));
    push(1'b0, 1'b0, 1'b0, o_wb(1'b1, 2'd1));
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL lw_wait step %0d got=%h required=%h", n, act, exp);
      end
      n++;
    end
    $display("tx lw_wait cycles=%0d", n);
    n = 0;
    instr_i = 32'h0020A223;
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, o_decode());
    push(1'b0, 1'b0, 1'b0, o_exec(4'b0000, 2'd0, 2'd1, 1'b0));
    push(1'b0, 1'b1, 1'b0, o_mem(1'b1));
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL sw step %0d got=%h required=%h", n, act, exp);
      end
      n++;
    end
    $display("tx sw cycles=%0d", n);
    n = 0;
    instr_i = 32'h0000A283;
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, o_decode());
    push(1'b0, 1'b0, 1'b0, o_exec(4'b0000, 2'd0, 2'd1, 1'b0));
    push(1'b1, 1'b0, 1'b0, o_mem(1'b0));
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL lw_reset step %0d got=%h required=%h", n, act, exp);
      end
      n++;
    end
    $display("tx lw_reset cycles=%0d", n);
  endtask

  task automatic test_trap();
    obs_t act, exp;
    int   n = 0;
    instr_i = 32'h0000007F;
    push(1'b0, 1'b1, 1'b0, o_fetch(1'b1));
    push(1'b0, 1'b0, 1'b0, o_decode());
    for (int i = 0; i < 12; i++) push(1'b0, i[0], i[1], o_trap());
    push(1'b1, 1'b1, 1'b0, o_trap());
    push(1'b0, 1'b0, 1'b0, o_fetch(1'b0));
    while (sb.size() > 0) begin
      advance(act, exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL trap step %0d got=%h required=%h", n, act, exp);
      end
      n++;
    end
    $display("tx trap cycles=%0d", n);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_load_store();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
